memory_responder: RTL and testbench

Back end of the load/store path: accepts one memory request at a time from the memory pipeline's address-generation stage and performs it on a single-ported memory bus with variable latency. Every request, load or store, then produces exactly one completion on a writeback channel for rename/ROB bookkeeping. A watchdog bounds load latency so a lost read response cannot hang the core.

---
 rtl/memory_responder.sv | 118 +++++++++++
 tb/tb_memory_responder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder: single-outstanding load/store back end with a bus FSM, writeback completion and a load watchdog.
module memory_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] req_addr,
    input  logic [4:0]  req_dest_reg,
    input  logic [7:0]  req_data,
    input  logic [7:0]  req_dest_arch_regs,
    input  logic        req_store,
    input  logic        req_valid,
    output logic        req_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_valid,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_rvalid,
    output logic [4:0]  wb_dest_reg,
    output logic [7:0]  wb_data,
    output logic [7:0]  wb_dest_arch_regs,
    output logic        wb_store,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [4:0]  dest_q, dest_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  arch_q, arch_d;
    logic        store_q, store_d;
    logic [7:0]  wb_data_q, wb_data_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        terr_q, terr_d;
    logic        accept;

    // rst_n gates ready so nothing looks acceptable while the block is held in reset
    assign req_ready = rst_n & ((state_q == IDLE) | ((state_q == DONE) & wb_ready));
    assign accept    = req_valid & req_ready;

    always_comb begin
        state_d   = state_q;
        addr_d    = accept ? req_addr           : addr_q;
        dest_d    = accept ? req_dest_reg       : dest_q;
        data_d    = accept ? req_data           : data_q;
        arch_d    = accept ? req_dest_arch_regs : arch_q;
        store_d   = accept ? req_store          : store_q;
        wb_data_d = wb_data_q;
        cnt_d     = cnt_q;
        terr_d    = terr_q;
        case (state_q)
            IDLE: state_d = accept ? ISSUE : IDLE;
            ISSUE: begin
                if (mem_ready) begin
                    state_d   = store_q ? DONE : WAIT;
                    wb_data_d = store_q ? data_q : wb_data_q;
                    cnt_d     = 8'd0;
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d   = DONE;
                    wb_data_d = mem_rdata;
                end else if (cnt_q == LIMIT) begin
                    state_d   = DONE;
                    wb_data_d = 8'hFF;
                    terr_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: state_d = wb_ready ? (accept ? ISSUE : IDLE) : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            dest_q    <= '0;
            data_q    <= '0;
            arch_q    <= '0;
            store_q   <= 1'b0;
            wb_data_q <= '0;
            cnt_q     <= '0;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            dest_q    <= dest_d;
            data_q    <= data_d;
            arch_q    <= arch_d;
            store_q   <= store_d;
            wb_data_q <= wb_data_d;
            cnt_q     <= cnt_d;
            terr_q    <= terr_d;
        end
    end

    assign mem_valid         = (state_q == ISSUE);
    assign mem_we            = (state_q == ISSUE) & store_q;
    assign mem_addr          = addr_q;
    assign mem_wdata         = data_q;
    assign wb_valid          = (state_q == DONE);
    assign wb_data           = wb_data_q;
    assign wb_dest_reg       = dest_q;
    assign wb_dest_arch_regs = arch_q;
    assign wb_store          = store_q;
    assign timeout_err       = terr_q;
endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed steps with a completion scoreboard for memory_responder (TIMEOUT_CYCLES=4).
module tb_memory_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req_addr = '0;
    logic [4:0]  req_dest_reg = '0;
    logic [7:0]  req_data = '0;
    logic [7:0]  req_dest_arch_regs = '0;
    logic        req_store = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        mem_rvalid = 1'b0;
    logic [4:0]  wb_dest_reg;
    logic [7:0]  wb_data;
    logic [7:0]  wb_dest_arch_regs;
    logic        wb_store;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic        timeout_err;

    typedef struct packed {
        logic [4:0] dest;
        logic [7:0] data;
        logic [7:0] arch;
        logic       store;
    } exp_t;

    exp_t sb[$];
    exp_t got;
    int   checks = 0;
    int   errors = 0;
    int   n_comp = 0;
    int   snap;

    memory_responder #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_addr(req_addr), .req_dest_reg(req_dest_reg), .req_data(req_data),
        .req_dest_arch_regs(req_dest_arch_regs), .req_store(req_store),
        .req_valid(req_valid), .req_ready(req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_rvalid(mem_rvalid),
        .wb_dest_reg(wb_dest_reg), .wb_data(wb_data),
        .wb_dest_arch_regs(wb_dest_arch_regs), .wb_store(wb_store),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [4:0] d, input logic [7:0] wd,
                         input logic [7:0] arch, input logic st);
        req_addr = a;
        req_dest_reg = d;
        req_data = wd;
        req_dest_arch_regs = arch;
        req_store = st;
        req_valid = 1'b1;
    endtask

    // completions are checked in order against what the stimulus queued
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1 && wb_ready === 1'b1) begin
            n_comp++;
            if (sb.size() == 0) chk("wb_unexpected", 32'(wb_valid), 32'(0));
            else begin
                got = sb.pop_front();
                chk("sb_dest", 32'(wb_dest_reg), 32'(got.dest));
                chk("sb_data", 32'(wb_data), 32'(got.data));
                chk("sb_arch", 32'(wb_dest_arch_regs), 32'(got.arch));
                chk("sb_store", 32'(wb_store), 32'(got.store));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_mem_valid", 32'(mem_valid), 32'(0));
        chk("rst_mem_addr", 32'(mem_addr), 32'(0));
        chk("rst_wb_valid", 32'(wb_valid), 32'(0));
        chk("rst_wb_data", 32'(wb_data), 32'(0));
        chk("rst_timeout", 32'(timeout_err), 32'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("post_rst_ready", 32'(req_ready), 32'(1));

        // store, 2-cycle latency
        tick();
        mem_ready = 1'b1;
        wb_ready = 1'b1;
        drive(16'h1234, 5'd5, 8'hAB, 8'h3C, 1'b1);
        sb.push_back('{5'd5, 8'hAB, 8'h3C, 1'b1});
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("st_mem_valid", 32'(mem_valid), 32'(1));
        chk("st_mem_we", 32'(mem_we), 32'(1));
        chk("st_mem_addr", 32'(mem_addr), 32'h1234);
        chk("st_mem_wdata", 32'(mem_wdata), 32'hAB);
        chk("st_wb_early", 32'(wb_valid), 32'(0));
        @(negedge clk);
        chk("st_wb_valid", 32'(wb_valid), 32'(1));
        chk("st_wb_store", 32'(wb_store), 32'(1));
        chk("st_wb_data", 32'(wb_data), 32'hAB);
        chk("st_wb_dest", 32'(wb_dest_reg), 32'd5);
        tick();

        // load, read data three cycles after acceptance
        drive(16'h0200, 5'd9, 8'h77, 8'hA5, 1'b0);
        sb.push_back('{5'd9, 8'h5C, 8'hA5, 1'b0});
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("ld_mem_valid", 32'(mem_valid), 32'(1));
        chk("ld_mem_we", 32'(mem_we), 32'(0));
        chk("ld_mem_addr", 32'(mem_addr), 32'h0200);
        tick();
        tick();
        mem_rvalid = 1'b1;
        mem_rdata = 8'h5C;
        @(negedge clk);
        chk("ld_wb_early", 32'(wb_valid), 32'(0));
        chk("ld_mem_idle", 32'(mem_valid), 32'(0));
        tick();
        mem_rvalid = 1'b0;
        mem_rdata = 8'h00;
        @(negedge clk);
        chk("ld_wb_valid", 32'(wb_valid), 32'(1));
        chk("ld_wb_data", 32'(wb_data), 32'h5C);
        chk("ld_wb_store", 32'(wb_store), 32'(0));
        chk("ld_wb_arch", 32'(wb_dest_arch_regs), 32'hA5);
        tick();

        // bus backpressure, then writeback backpressure
        mem_ready = 1'b0;
        wb_ready = 1'b0;
        drive(16'hBEEF, 5'd3, 8'h42, 8'h11, 1'b1);
        sb.push_back('{5'd3, 8'h42, 8'h11, 1'b1});
        tick();
        req_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("bp_mem_valid", 32'(mem_valid), 32'(1));
            chk("bp_mem_addr", 32'(mem_addr), 32'hBEEF);
            chk("bp_mem_wdata", 32'(mem_wdata), 32'h42);
            chk("bp_mem_we", 32'(mem_we), 32'(1));
            chk("bp_req_ready", 32'(req_ready), 32'(0));
            tick();
        end
        mem_ready = 1'b1;
        tick();
        drive(16'h0010, 5'd1, 8'h11, 8'h01, 1'b1);
        sb.push_back('{5'd1, 8'h11, 8'h01, 1'b1});
        repeat (3) begin
            @(negedge clk);
            chk("bp_wb_valid", 32'(wb_valid), 32'(1));
            chk("bp_wb_data", 32'(wb_data), 32'h42);
            chk("bp_wb_dest", 32'(wb_dest_reg), 32'd3);
            chk("bp_wb_store", 32'(wb_store), 32'(1));
            chk("bp_no_accept", 32'(req_ready), 32'(0));
            tick();
        end

        // back-to-back stores, completions two cycles apart
        wb_ready = 1'b1;
        @(negedge clk);
        chk("b2b_ready_done", 32'(req_ready), 32'(1));
        tick();
        drive(16'h0020, 5'd2, 8'h22, 8'h02, 1'b1);
        sb.push_back('{5'd2, 8'h22, 8'h02, 1'b1});
        @(negedge clk);
        chk("b2b_issue_b", 32'(mem_addr), 32'h0010);
        chk("b2b_ready_issue", 32'(req_ready), 32'(0));
        tick();
        @(negedge clk);
        chk("b2b_wb_b", 32'(wb_valid), 32'(1));
        chk("b2b_wb_b_data", 32'(wb_data), 32'h11);
        chk("b2b_ready_b", 32'(req_ready), 32'(1));
        tick();
        req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_gap", 32'(wb_valid), 32'(0));
        chk("b2b_issue_c", 32'(mem_addr), 32'h0020);
        tick();
        @(negedge clk);
        chk("b2b_wb_c", 32'(wb_valid), 32'(1));
        chk("b2b_wb_c_data", 32'(wb_data), 32'h22);
        tick();

        // load timeout with no read response
        drive(16'h0300, 5'd7, 8'h00, 8'h80, 1'b0);
        sb.push_back('{5'd7, 8'hFF, 8'h80, 1'b0});
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("to_wb_early", 32'(wb_valid), 32'(0));
            chk("to_err_early", 32'(timeout_err), 32'(0));
            @(posedge clk);
        end
        #1;
        @(negedge clk);
        chk("to_wb_valid", 32'(wb_valid), 32'(1));
        chk("to_wb_data", 32'(wb_data), 32'hFF);
        chk("to_err", 32'(timeout_err), 32'(1));
        tick();
        mem_rvalid = 1'b1;
        mem_rdata = 8'h99;
        @(negedge clk);
        chk("stray_wb", 32'(wb_valid), 32'(0));
        chk("stray_ready", 32'(req_ready), 32'(1));
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("stray_wb_after", 32'(wb_valid), 32'(0));
        chk("stray_mem_valid", 32'(mem_valid), 32'(0));
        chk("to_err_sticky", 32'(timeout_err), 32'(1));
        tick();

        // asynchronous reset while waiting for a load
        drive(16'h0400, 5'd2, 8'h00, 8'h44, 1'b0);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        snap = n_comp;
        #3 rst_n = 1'b0;
        #1;
        chk("ar_mem_valid", 32'(mem_valid), 32'(0));
        chk("ar_mem_addr", 32'(mem_addr), 32'(0));
        chk("ar_wb_valid", 32'(wb_valid), 32'(0));
        chk("ar_wb_dest", 32'(wb_dest_reg), 32'(0));
        chk("ar_timeout", 32'(timeout_err), 32'(0));
        chk("ar_req_ready", 32'(req_ready), 32'(0));
        tick();
        rst_n = 1'b1;
        #1 chk("ar_ready_after", 32'(req_ready), 32'(1));
        tick();
        mem_rvalid = 1'b1;
        mem_rdata = 8'h33;
        tick();
        mem_rvalid = 1'b0;
        repeat (6) tick();
        chk("ar_no_completion", 32'(n_comp), 32'(snap));
        chk("ar_wb_quiet", 32'(wb_valid), 32'(0));
        chk("sb_drained", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
